// File: rtl/mops_step_gen_if.sv
// mops_step_gen_if: control, configuration and sample bundle of the MoPS staircase generator
interface mops_step_gen_if #(
  parameter int ADC_WIDTH = 12,
  parameter int MAX_STEPS_BITS = 4,
  parameter int GAP_BITS = 8
);
  logic [1:0] ENABLE40;
  logic START;
  logic [ADC_WIDTH-1:0] BASELINE;
  logic [ADC_WIDTH-1:0] STEP_SIZE;
  logic [MAX_STEPS_BITS-1:0] N_STEPS;
  logic [GAP_BITS-1:0] GAP;
  logic [2:0] DECAY_SHIFT;
  logic [2:0] PMT_MASK;
  logic [ADC_WIDTH-1:0] ADC0;
  logic [ADC_WIDTH-1:0] ADC1;
  logic [ADC_WIDTH-1:0] ADC2;
  logic BUSY;
  logic DONE;
  modport master (
    output ENABLE40, START, BASELINE, STEP_SIZE, N_STEPS, GAP, DECAY_SHIFT, PMT_MASK,
    input ADC0, ADC1, ADC2, BUSY, DONE
  );
  modport slave (
    input ENABLE40, START, BASELINE, STEP_SIZE, N_STEPS, GAP, DECAY_SHIFT, PMT_MASK,
    output ADC0, ADC1, ADC2, BUSY, DONE
  );
endinterface

// File: rtl/mops_step_gen.sv
// mops_step_gen: synthesizes step-then-dip staircase bursts with exponential-ish tail on up to three ADC channels
module mops_step_gen #(
  parameter int ADC_WIDTH = 12,
  parameter int MAX_STEPS_BITS = 4,
  parameter int GAP_BITS = 8
) (
  input logic CLK120,
  input logic RESETN,
  mops_step_gen_if.slave bus
);
  localparam int W = ADC_WIDTH;
  typedef enum logic [2:0] {IDLE, STEP, DIP, HOLD, DECAY} state_t;
  state_t state, state_n, after_hold;
  logic [W-1:0] level, level_n, base_c, step_c, delta, shr;
  logic [W:0] sum;
  logic [MAX_STEPS_BITS-1:0] n_c, cnt, cnt_n;
  logic [GAP_BITS-1:0] gap_c, gap_cnt, gap_n;
  logic [2:0] shift_c, mask_c;
  logic pending, was_rst, done_n, tick, consume;
  assign tick = bus.ENABLE40 == 2'd0;
  assign consume = tick && state == IDLE && pending;
  assign bus.BUSY = state != IDLE;
  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n = cnt;
    gap_n = gap_cnt;
    done_n = 1'b0;
    sum = {1'b0, level} + {1'b0, step_c};
    delta = level - base_c;
    shr = delta >> shift_c;
    after_hold = (cnt == n_c) ? DECAY : STEP;
    if (tick)
      case (state)
        IDLE: begin
          level_n = bus.BASELINE;
          cnt_n = '0;
          if (pending) begin
            state_n = (bus.N_STEPS != '0) ? STEP : IDLE;
            done_n = bus.N_STEPS == '0;
          end
        end
        STEP: begin
          level_n = sum[W] ? '1 : sum[W-1:0];
          cnt_n = cnt + 1'b1;
          state_n = DIP;
        end
        DIP: begin
          level_n = (level > base_c) ? level - 1'b1 : level;
          gap_n = gap_c;
          state_n = (gap_c != '0) ? HOLD : after_hold;
        end
        HOLD: begin
          gap_n = gap_cnt - 1'b1;
          state_n = (gap_cnt == GAP_BITS'(1)) ? after_hold : HOLD;
        end
        DECAY: begin
          // at least one LSB per tick so small residues still settle onto the baseline
          level_n = (delta == '0) ? level : level - ((shr == '0) ? W'(1) : shr);
          state_n = (delta == '0) ? IDLE : DECAY;
          done_n = delta == '0;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK120) begin
    if (!RESETN) begin
      state <= IDLE;
      level <= '0;
      cnt <= '0;
      gap_cnt <= '0;
      pending <= 1'b0;
      was_rst <= 1'b1;
      base_c <= '0;
      step_c <= '0;
      n_c <= '0;
      gap_c <= '0;
      shift_c <= '0;
      mask_c <= '0;
      bus.DONE <= 1'b0;
      bus.ADC0 <= '0;
      bus.ADC1 <= '0;
      bus.ADC2 <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      cnt <= cnt_n;
      gap_cnt <= gap_n;
      was_rst <= 1'b0;
      bus.DONE <= done_n;
      // a START in the first cycle out of reset is dropped
      pending <= consume ? 1'b0 : pending | (bus.START & ~bus.BUSY & ~was_rst);
      if (consume) begin
        base_c <= bus.BASELINE;
        step_c <= bus.STEP_SIZE;
        n_c <= bus.N_STEPS;
        gap_c <= bus.GAP;
        shift_c <= bus.DECAY_SHIFT;
        mask_c <= bus.PMT_MASK;
      end
      if (tick) begin
        bus.ADC0 <= (state == IDLE) ? bus.BASELINE : mask_c[0] ? level_n : base_c;
        bus.ADC1 <= (state == IDLE) ? bus.BASELINE : mask_c[1] ? level_n : base_c;
        bus.ADC2 <= (state == IDLE) ? bus.BASELINE : mask_c[2] ? level_n : base_c;
      end
    end
  end
endmodule

// File: tb/tb_mops_step_gen.sv
// tb_mops_step_gen: table-driven burst vectors plus reset, zero-step and restart corner sequences
module tb_mops_step_gen;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  mops_step_gen_if bus ();
  mops_step_gen dut (.CLK120(clk), .RESETN(rstn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] base, step;
    logic [3:0] n;
    logic [7:0] gap;
    logic [2:0] sh, mask;
    logic [0:8][11:0] e0, e1;
    int nchk;
    int span;
    bit restart;
  } vec_t;
  vec_t v[4];
  initial begin
    bus.ENABLE40 = 2'd0;
    forever begin
      @(negedge clk);
      bus.ENABLE40 = (bus.ENABLE40 == 2'd2) ? 2'd0 : 2'(bus.ENABLE40 + 2'd1);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, elapsed %0t required below 500000", $time);
    $fatal(1);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic next_tick;
    bit t;
    do begin
      @(posedge clk);
      t = bus.ENABLE40 == 2'd0;
      #1;
    end while (!t);
  endtask
  task automatic pulse_start;
    @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask
  task automatic apply(input int i);
    bus.BASELINE = v[i].base;
    bus.STEP_SIZE = v[i].step;
    bus.N_STEPS = v[i].n;
    bus.GAP = v[i].gap;
    bus.DECAY_SHIFT = v[i].sh;
    bus.PMT_MASK = v[i].mask;
  endtask
  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 10 && !ok; g++) begin
      next_tick;
      ok = bus.BUSY;
    end
    chk("busy_rise", int'(ok), 1);
  endtask
  task automatic run_burst(input int i);
    bit ok, ended;
    int k, span;
    apply(i);
    pulse_start;
    wait_busy(ok);
    if (!ok) return;
    chk($sformatf("v%0d_adc0[0]", i), int'(bus.ADC0), int'(v[i].e0[0]));
    chk($sformatf("v%0d_adc1[0]", i), int'(bus.ADC1), int'(v[i].e1[0]));
    chk($sformatf("v%0d_adc2[0]", i), int'(bus.ADC2), int'(v[i].e0[0]));
    // inputs move mid-burst; the captured configuration must hold
    bus.BASELINE = 12'd777;
    bus.STEP_SIZE = 12'd1;
    bus.N_STEPS = 4'd9;
    bus.GAP = 8'd5;
    bus.DECAY_SHIFT = 3'd0;
    bus.PMT_MASK = 3'b000;
    k = 1;
    span = 1;
    ended = 1'b0;
    for (int g = 0; g < 500 && !ended; g++) begin
      next_tick;
      if (k < v[i].nchk) begin
        chk($sformatf("v%0d_adc0[%0d]", i, k), int'(bus.ADC0), int'(v[i].e0[k]));
        chk($sformatf("v%0d_adc1[%0d]", i, k), int'(bus.ADC1), int'(v[i].e1[k]));
        chk($sformatf("v%0d_adc2[%0d]", i, k), int'(bus.ADC2), int'(v[i].e0[k]));
      end
      if (v[i].restart && k == 3) pulse_start;
      k++;
      if (bus.BUSY) span++;
      else ended = 1'b1;
    end
    chk($sformatf("v%0d_burst_end", i), int'(ended), 1);
    chk($sformatf("v%0d_busy_span", i), span, v[i].span);
    chk($sformatf("v%0d_done_hi", i), int'(bus.DONE), 1);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_lo", i), int'(bus.DONE), 0);
    for (int g = 0; g < (v[i].restart ? 6 : 1); g++) begin
      next_tick;
      chk($sformatf("v%0d_idle_busy", i), int'(bus.BUSY), 0);
    end
    chk($sformatf("v%0d_idle_adc0", i), int'(bus.ADC0), 777);
  endtask
  initial begin
    bit ok, seen_busy;
    int dones;
    v[0] = '{base: 12'd250, step: 12'd40, n: 4'd3, gap: 8'd2, sh: 3'd2, mask: 3'b101,
             e0: {12'd250, 12'd290, 12'd289, 12'd289, 12'd289, 12'd329, 12'd328, 12'd328, 12'd328},
             e1: {9{12'd250}}, nchk: 9, span: 30, restart: 1'b1};
    v[1] = '{base: 12'd4000, step: 12'd100, n: 4'd2, gap: 8'd0, sh: 3'd1, mask: 3'b111,
             e0: {12'd4000, 12'd4095, 12'd4094, 12'd4095, 12'd4094, 12'd4047, 12'd4024, 12'd0, 12'd0},
             e1: {12'd4000, 12'd4095, 12'd4094, 12'd4095, 12'd4094, 12'd4047, 12'd4024, 12'd0, 12'd0},
             nchk: 7, span: 13, restart: 1'b0};
    v[2] = '{base: 12'd100, step: 12'd0, n: 4'd2, gap: 8'd1, sh: 3'd0, mask: 3'b001,
             e0: {9{12'd100}}, e1: {9{12'd100}}, nchk: 8, span: 7, restart: 1'b0};
    v[3] = '{base: 12'd0, step: 12'd10, n: 4'd1, gap: 8'd0, sh: 3'd3, mask: 3'b010,
             e0: {9{12'd0}},
             e1: {12'd0, 12'd10, 12'd9, 12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd0},
             nchk: 8, span: 12, restart: 1'b0};
    bus.START = 1'b0;
    apply(0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_adc0", int'(bus.ADC0), 0);
    chk("rst_adc1", int'(bus.ADC1), 0);
    chk("rst_adc2", int'(bus.ADC2), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_done", int'(bus.DONE), 0);
    @(negedge clk);
    rstn = 1'b1;
    next_tick;
    chk("post_rst_adc0", int'(bus.ADC0), 250);
    chk("post_rst_adc1", int'(bus.ADC1), 250);
    for (int i = 0; i < 4; i++) run_burst(i);
    bus.N_STEPS = 4'd0;
    bus.BASELINE = 12'd500;
    pulse_start;
    seen_busy = 1'b0;
    dones = 0;
    for (int g = 0; g < 12; g++) begin
      @(posedge clk);
      #1;
      seen_busy |= bus.BUSY;
      dones += int'(bus.DONE);
    end
    chk("zero_busy", int'(seen_busy), 0);
    chk("zero_done_cycles", dones, 1);
    chk("zero_adc0", int'(bus.ADC0), 500);
    apply(0);
    pulse_start;
    wait_busy(ok);
    for (int g = 0; g < 7; g++) next_tick;
    chk("hold2_adc0", int'(bus.ADC0), 328);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_adc0", int'(bus.ADC0), 0);
    chk("midrst_adc1", int'(bus.ADC1), 0);
    chk("midrst_adc2", int'(bus.ADC2), 0);
    chk("midrst_busy", int'(bus.BUSY), 0);
    chk("midrst_done", int'(bus.DONE), 0);
    bus.BASELINE = 12'd321;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    for (int g = 0; g < 6; g++) begin
      next_tick;
      chk("rel_start_busy", int'(bus.BUSY), 0);
      chk("rel_adc0", int'(bus.ADC0), 321);
    end
    run_burst(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
